// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the two requester ports, the data-memory port and busy of dmem_arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; the arbiter side is the slave modport.
// Ports: req/we/addr/wdata 0/1 in, ack/err/rdata 0/1 out, mem_a/mem_wd/mem_we out,
//        mem_rd in (combinational memory read data), busy out.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        output ack0, ack1, err0, err1, rdata0, rdata1, mem_a, mem_wd, mem_we, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
        input  ack0, ack1, err0, err1, rdata0, rdata1, mem_a, mem_wd, mem_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: two-port round-robin arbiter in front of a 32-word data memory.
// Latency: IDLE -> ACCESS -> RESP, ack in the second cycle after the sampling edge; 1 access / 3 cycles.
// Backpressure: requests are held until ack; only sampled in IDLE, loser keeps waiting.
// Ports: clk, rst (sync active-high), bus (dmem_arbiter_if.slave): requester ports 0/1,
//        memory port mem_a/mem_wd/mem_we/mem_rd, busy.
module dmem_arbiter (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        last_grant;   // port granted most recently
    logic        win;          // owner of the transaction in flight
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;

    logic        grant_any;
    logic        grant_sel;
    logic        in_range;

    assign grant_any = bus.req0 | bus.req1;
    // On a tie the port that did not win last time gets it; otherwise the lone requester.
    assign grant_sel = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    assign in_range  = (lat_addr < 32'd32);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            win        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            if (state == IDLE && grant_any) begin
                win        <= grant_sel;
                last_grant <= grant_sel;
                lat_we     <= grant_sel ? bus.we1    : bus.we0;
                lat_addr   <= grant_sel ? bus.addr1  : bus.addr0;
                lat_wdata  <= grant_sel ? bus.wdata1 : bus.wdata0;
            end
            // Writes and suppressed accesses report zero read data.
            if (state == ACCESS) begin
                rdata_q <= (in_range && !lat_we) ? bus.mem_rd : 32'd0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        bus.mem_a  = 32'd0;
        bus.mem_wd = 32'd0;
        bus.mem_we = 1'b0;
        bus.ack0   = 1'b0;
        bus.ack1   = 1'b0;
        bus.err0   = 1'b0;
        bus.err1   = 1'b0;
        bus.rdata0 = 32'd0;
        bus.rdata1 = 32'd0;
        bus.busy   = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                // Out-of-range addresses leave the memory port completely quiet.
                if (in_range) begin
                    bus.mem_a  = lat_addr;
                    bus.mem_wd = lat_wdata;
                    bus.mem_we = lat_we;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (win) begin
                    bus.ack1   = 1'b1;
                    bus.err1   = ~in_range;
                    bus.rdata1 = rdata_q;
                end else begin
                    bus.ack0   = 1'b1;
                    bus.err0   = ~in_range;
                    bus.rdata0 = rdata_q;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
